// File: rtl/argmax_layer_if.sv
// Stream bundle for argmax_layer: score beats in, one {max_score, class_index} word out.
// ARGMAX_EOP_CHECK_EN adds the frame_err result flag.
interface argmax_layer_if #(
    parameter int unsigned DIN_W  = 32,
    parameter int unsigned DOUT_W = 32
);
    logic [DIN_W-1:0]  blob_din;
    logic              blob_din_en;
    logic              blob_din_eop;
    logic              blob_din_rdy;
    logic [DOUT_W-1:0] blob_dout;
    logic              blob_dout_en;
    logic              blob_dout_eop;
    logic              blob_dout_rdy;
`ifdef ARGMAX_EOP_CHECK_EN
    logic              frame_err;
`endif

    // Producer of scores and consumer of results
    modport master (
        output blob_din,
        output blob_din_en,
        output blob_din_eop,
        input  blob_din_rdy,
        input  blob_dout,
        input  blob_dout_en,
        input  blob_dout_eop,
`ifdef ARGMAX_EOP_CHECK_EN
        input  frame_err,
`endif
        output blob_dout_rdy
    );

    // The argmax stage itself
    modport slave (
        input  blob_din,
        input  blob_din_en,
        input  blob_din_eop,
        output blob_din_rdy,
        output blob_dout,
        output blob_dout_en,
        output blob_dout_eop,
`ifdef ARGMAX_EOP_CHECK_EN
        output frame_err,
`endif
        input  blob_dout_rdy
    );
endinterface

// File: rtl/argmax_layer.sv
// argmax_layer: streaming signed argmax over NUM_CLASS scores, LANES per beat, one result per frame.
// Define ARGMAX_EOP_CHECK_EN to terminate frames on eop and report length errors on frame_err.
module argmax_layer #(
    parameter int unsigned NUM_CLASS = 10,
    parameter int unsigned LANES     = 2,
    parameter int unsigned DW        = 16,
    parameter int unsigned IDX_W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    argmax_layer_if.slave bus
);
    localparam int unsigned BEATS = (NUM_CLASS + LANES - 1) / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OW    = DW + IDX_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic signed [DW-1:0] best_val_q, best_val_d;
    logic [IDX_W-1:0]     best_idx_q, best_idx_d;
    logic                 din_rdy_q, din_rdy_d;
    logic                 dout_en_q, dout_en_d;
    logic [OW-1:0]        dout_q, dout_d;

    logic                 accept_c;
    logic                 last_c;
    logic                 frame_end_c;
    logic signed [DW-1:0] cand_val_c;
    logic [IDX_W-1:0]     cand_idx_c;

    assign accept_c = bus.blob_din_en & din_rdy_q;
    assign last_c   = (beat_cnt_q == CNT_W'(BEATS - 1));

`ifdef ARGMAX_EOP_CHECK_EN
    logic err_q, err_d;
    logic err_c;

    // An eop on a non-final beat ends the frame early; either length mismatch flags an error
    assign frame_end_c   = accept_c & (last_c | bus.blob_din_eop);
    assign err_c         = bus.blob_din_eop ^ last_c;
    assign bus.frame_err = err_q;
`else
    logic unused_eop;

    assign frame_end_c = accept_c & last_c;
    assign unused_eop  = bus.blob_din_eop;
`endif

    // Fold this beat's lanes into the running best; first beat of a frame seeds from lane 0
    always_comb begin : lane_scan
        logic signed [DW-1:0] lane_v;
        int unsigned          cls;
        lane_v     = '0;
        cls        = 0;
        cand_val_c = best_val_q;
        cand_idx_c = best_idx_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_v = $signed(bus.blob_din[l*DW +: DW]);
            cls    = 32'(beat_cnt_q) * LANES + l;
            if (cls < NUM_CLASS) begin
                if (((state_q == S_IDLE) && (l == 0)) || (lane_v > cand_val_c)) begin
                    cand_val_c = lane_v;
                    cand_idx_c = IDX_W'(cls);
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin : fsm_next
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = frame_end_c ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                if (frame_end_c) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.blob_dout_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: next values of the registered handshake and result signals
    always_comb begin : fsm_out
        din_rdy_d = (state_d != S_OUT);
        dout_en_d = dout_en_q;
        dout_d    = dout_q;
`ifdef ARGMAX_EOP_CHECK_EN
        err_d     = err_q;
`endif
        if (frame_end_c) begin
            dout_en_d = 1'b1;
            dout_d    = {cand_val_c, cand_idx_c};
`ifdef ARGMAX_EOP_CHECK_EN
            err_d     = err_c;
`endif
        end else if ((state_q == S_OUT) && bus.blob_dout_rdy) begin
            dout_en_d = 1'b0;
`ifdef ARGMAX_EOP_CHECK_EN
            err_d     = 1'b0;
`endif
        end
    end

    // Running best and beat counter; best_* hold after the frame until the next seed
    always_comb begin : datapath_next
        beat_cnt_d = beat_cnt_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        if (accept_c) begin
            best_val_d = cand_val_c;
            best_idx_d = cand_idx_c;
            beat_cnt_d = frame_end_c ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_q <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            din_rdy_q  <= 1'b0;
            dout_en_q  <= 1'b0;
            dout_q     <= '0;
`ifdef ARGMAX_EOP_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            beat_cnt_q <= beat_cnt_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            din_rdy_q  <= din_rdy_d;
            dout_en_q  <= dout_en_d;
            dout_q     <= dout_d;
`ifdef ARGMAX_EOP_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign bus.blob_din_rdy  = din_rdy_q;
    assign bus.blob_dout     = dout_q;
    assign bus.blob_dout_en  = dout_en_q;
    assign bus.blob_dout_eop = dout_en_q;

endmodule

// File: tb/tb_argmax_layer.sv
// Self-checking bench for argmax_layer: directed and random frames against a plain argmax model.
module tb_argmax_layer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [15:0] frame_sc [10];

    always #5 clk = ~clk;

    argmax_layer_if #(.DIN_W(32), .DOUT_W(32)) bus ();

    argmax_layer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: first index holding the largest signed score among classes 0..n-1
    function automatic logic [31:0] ref_argmax(input int n);
        int best_i;
        best_i = 0;
        for (int i = 1; i < n; i++) begin
            if ($signed(frame_sc[i]) > $signed(frame_sc[best_i])) best_i = i;
        end
        return {frame_sc[best_i], 16'(best_i)};
    endfunction

    task automatic send_frame(input string tag, input int nbeats, input int eop_beat, input int max_gap);
        int gap;
        int budget;
        for (int k = 0; k < nbeats; k++) begin
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            bus.blob_din_en  = 1'b0;
            bus.blob_din_eop = 1'b0;
            repeat (gap) step();
            bus.blob_din     = {frame_sc[2*k+1], frame_sc[2*k]};
            bus.blob_din_eop = (k == eop_beat);
            bus.blob_din_en  = 1'b1;
            budget = 0;
            while (!bus.blob_din_rdy && budget < 50) begin
                step();
                budget++;
            end
            if (!bus.blob_din_rdy) check1({tag, "_accept_timeout"}, bus.blob_din_rdy, 1'b1);
            if (k == nbeats - 1) check1({tag, "_en_before_last"}, bus.blob_dout_en, 1'b0);
            step();
        end
        bus.blob_din_en  = 1'b0;
        bus.blob_din_eop = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int nbeats, input int eop_beat,
                             input int max_gap, input int stall);
        logic [31:0] exp;
        int          ncls;
        ncls = (nbeats * 2 > 10) ? 10 : nbeats * 2;
        exp  = ref_argmax(ncls);
        bus.blob_dout_rdy = (stall == 0);
        send_frame(tag, nbeats, eop_beat, max_gap);
        check1 ({tag, "_en"},      bus.blob_dout_en,  1'b1);
        check1 ({tag, "_eop"},     bus.blob_dout_eop, 1'b1);
        check32({tag, "_dout"},    bus.blob_dout,     exp);
        check1 ({tag, "_din_rdy"}, bus.blob_din_rdy,  1'b0);
`ifdef ARGMAX_EOP_CHECK_EN
        check1 ({tag, "_err"},     bus.frame_err,     eop_beat != 4);
`endif
        for (int s = 0; s < stall; s++) begin
            bus.blob_din_en = 1'b1;
            step();
            check1 ({tag, "_hold_en"},      bus.blob_dout_en, 1'b1);
            check32({tag, "_hold_dout"},    bus.blob_dout,    exp);
            check1 ({tag, "_hold_din_rdy"}, bus.blob_din_rdy, 1'b0);
        end
        bus.blob_din_en   = 1'b0;
        bus.blob_dout_rdy = 1'b1;
        step();
        check1({tag, "_en_clr"},   bus.blob_dout_en,  1'b0);
        check1({tag, "_eop_clr"},  bus.blob_dout_eop, 1'b0);
        check1({tag, "_rdy_back"}, bus.blob_din_rdy,  1'b1);
`ifdef ARGMAX_EOP_CHECK_EN
        check1({tag, "_err_clr"},  bus.frame_err,     1'b0);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t1 [10];
        n_cmp = 0;
        n_err = 0;
        rst               = 1'b0;
        bus.blob_din      = '0;
        bus.blob_din_en   = 1'b0;
        bus.blob_din_eop  = 1'b0;
        bus.blob_dout_rdy = 1'b0;

        // Reset state
        repeat (3) step();
        check1 ("rst_din_rdy",  bus.blob_din_rdy,  1'b0);
        check1 ("rst_dout_en",  bus.blob_dout_en,  1'b0);
        check1 ("rst_dout_eop", bus.blob_dout_eop, 1'b0);
        check32("rst_dout",     bus.blob_dout,     32'h0);
        rst = 1'b1;
        step();
        check1("rel_din_rdy", bus.blob_din_rdy, 1'b1);
        check1("rel_dout_en", bus.blob_dout_en, 1'b0);

        // Mixed scores with a tie and a clear maximum
        t1 = '{5, -3, 7, 7, 2, 0, -1, 100, 4, 8};
        for (int i = 0; i < 10; i++) frame_sc[i] = 16'(t1[i]);
        run_frame("t1", 5, 4, 0, 0);

        // All most-negative: ties resolve to index 0
        for (int i = 0; i < 10; i++) frame_sc[i] = 16'h8000;
        run_frame("t2", 5, 4, 0, 0);

        // Downstream stall for 6 cycles
        for (int i = 0; i < 10; i++) frame_sc[i] = 16'($urandom());
        run_frame("t3", 5, 4, 0, 6);

        // Back-to-back random frames, gapped input, random stalls, tie-heavy half
        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < 10; i++) begin
                if (f % 2 == 1) frame_sc[i] = 16'($urandom_range(0, 4)) - 16'd2;
                else            frame_sc[i] = 16'($urandom());
            end
            if (f == 4) frame_sc[9] = 16'h7fff;
            run_frame($sformatf("t4_f%0d", f), 5, 4, 2, int'($urandom_range(0, 3)));
        end

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 10; i++) frame_sc[i] = 16'h0050;
        bus.blob_dout_rdy = 1'b1;
        send_frame("t5_part", 3, -1, 0);
        check1("t5_no_result", bus.blob_dout_en, 1'b0);
        rst = 1'b0;
        #2;
        check1 ("t5_rst_din_rdy", bus.blob_din_rdy, 1'b0);
        check1 ("t5_rst_en",      bus.blob_dout_en, 1'b0);
        check32("t5_rst_dout",    bus.blob_dout,    32'h0);
        step();
        rst = 1'b1;
        step();
        check1("t5_rel_din_rdy", bus.blob_din_rdy, 1'b1);
        for (int i = 0; i < 10; i++) frame_sc[i] = 16'h0;
        frame_sc[9] = 16'd1;
        run_frame("t5", 5, 4, 0, 0);

        // Early eop handling
        t1 = '{1, 2, 3, 0, 7, 5, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) frame_sc[i] = 16'(t1[i]);
`ifdef ARGMAX_EOP_CHECK_EN
        run_frame("t6_early", 3, 2, 0, 0);
        run_frame("t6_full", 5, 4, 0, 0);
        run_frame("t6_noeop", 5, -1, 0, 2);
`else
        frame_sc[8] = 16'd9;
        run_frame("t6_eop_ignored", 5, 2, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
